// File: rtl/decode_stage_v2_if.sv
// Bundle of the decode stage's fetch-side, writeback, execute-side and perf signals.
// Master is the surrounding pipeline; slave is the decode stage itself.
interface decode_stage_v2_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 16,
    parameter int OPCODE_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH      = 16
);
    localparam int INSTR_WIDTH = OPCODE_WIDTH + 2 * REG_ADDR_WIDTH + IMM_WIDTH;
    localparam int CTRL_WIDTH  = OPCODE_WIDTH + REG_ADDR_WIDTH + 3;

    // in_valid/in_ready and out_valid/out_ready are strict valid/ready pairs: a
    // transfer happens on a rising edge where both are 1; valid must not depend on ready.
    logic [PC_WIDTH-1:0]       pc_in;
    logic [INSTR_WIDTH-1:0]    instr;
    logic                      in_valid;
    logic                      in_ready;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0]     reg_data;
    logic                      reg_en;
    logic                      flush;
    logic [DATA_WIDTH-1:0]     A;
    logic [DATA_WIDTH-1:0]     B;
    logic [DATA_WIDTH-1:0]     imm;
    logic [CTRL_WIDTH-1:0]     ctrl;
    logic [PC_WIDTH-1:0]       pc_out;
    logic                      out_valid;
    logic                      out_ready;
    logic                      hazard;
    logic [31:0]               perf_issued;
    logic [31:0]               perf_bubbles;

    modport master (
        output pc_in, instr, in_valid, reg_addr, reg_data, reg_en, flush, out_ready,
        input  in_ready, A, B, imm, ctrl, pc_out, out_valid, hazard, perf_issued, perf_bubbles
    );

    modport slave (
        input  pc_in, instr, in_valid, reg_addr, reg_data, reg_en, flush, out_ready,
        output in_ready, A, B, imm, ctrl, pc_out, out_valid, hazard, perf_issued, perf_bubbles
    );
endinterface

// File: rtl/decode_stage_v2.sv
// Decode/register-read stage: regfile with write bypass, load-use stall, output skid-free pipeline register.
// Optional macro DECODE_PERF_CNT_EN enables the issued/bubble performance counters.
module decode_stage_v2 #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 16,
    parameter int OPCODE_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH      = 16,
    parameter int R0_ZERO        = 1
) (
    input logic         clk_in,
    input logic         RST,
    decode_stage_v2_if.slave bus
);
    localparam int INSTR_WIDTH = OPCODE_WIDTH + 2 * REG_ADDR_WIDTH + IMM_WIDTH;
    localparam int CTRL_WIDTH  = OPCODE_WIDTH + REG_ADDR_WIDTH + 3;
    localparam int NREG        = 1 << REG_ADDR_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_DIV  = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOT  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_CALL = OPCODE_WIDTH'(13);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = OPCODE_WIDTH'(15);

    // Bit positions inside ctrl = {wb_en, mem_rd, mem_wr, rd_addr, opcode}
    localparam int CTRL_RD_LSB  = OPCODE_WIDTH;
    localparam int CTRL_MEM_RD  = OPCODE_WIDTH + REG_ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0]     rf [NREG];

    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [IMM_WIDTH-1:0]      imm_field;

    logic [DATA_WIDTH-1:0]     rd_a;
    logic [DATA_WIDTH-1:0]     rd_b;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [CTRL_WIDTH-1:0]     ctrl_dec;
    logic                      wb_en_dec;

    logic [DATA_WIDTH-1:0]     a_q;
    logic [DATA_WIDTH-1:0]     b_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [CTRL_WIDTH-1:0]     ctrl_q;
    logic [PC_WIDTH-1:0]       pc_q;
    logic                      valid_q;

    logic                      advance;
    logic                      hazard_w;
    logic                      in_ready_w;
    logic                      accept;
    logic [REG_ADDR_WIDTH-1:0] q_rd_addr;

    function automatic logic is_zero_reg(input logic [REG_ADDR_WIDTH-1:0] addr);
        return (R0_ZERO != 0) && (addr == '0);
    endfunction

    assign opcode    = bus.instr[0 +: OPCODE_WIDTH];
    assign rs1       = bus.instr[OPCODE_WIDTH +: REG_ADDR_WIDTH];
    assign rs2       = bus.instr[OPCODE_WIDTH + REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign imm_field = bus.instr[OPCODE_WIDTH + 2 * REG_ADDR_WIDTH +: IMM_WIDTH];
    assign imm_ext   = {{(DATA_WIDTH - IMM_WIDTH){imm_field[IMM_WIDTH-1]}}, imm_field};

    always_comb begin
        wb_en_dec = 1'b0;
        case (opcode)
            OP_LW, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_AND, OP_OR, OP_NOT, OP_CALL: wb_en_dec = 1'b1;
            default:                        wb_en_dec = 1'b0;
        endcase
    end

    assign ctrl_dec = {wb_en_dec, (opcode == OP_LW), (opcode == OP_SW), rs1, opcode};

    // A writeback landing in the same cycle as the read wins over the stored value.
    always_comb begin
        rd_a = rf[rs1];
        if (is_zero_reg(rs1))                           rd_a = '0;
        else if (bus.reg_en && (bus.reg_addr == rs1))   rd_a = bus.reg_data;
    end

    always_comb begin
        rd_b = rf[rs2];
        if (is_zero_reg(rs2))                           rd_b = '0;
        else if (bus.reg_en && (bus.reg_addr == rs2))   rd_b = bus.reg_data;
    end

    assign q_rd_addr  = ctrl_q[CTRL_RD_LSB +: REG_ADDR_WIDTH];
    assign advance    = !valid_q || bus.out_ready;
    assign hazard_w   = bus.in_valid && valid_q && ctrl_q[CTRL_MEM_RD] &&
                        ((q_rd_addr == rs1) || (q_rd_addr == rs2)) &&
                        !is_zero_reg(q_rd_addr);
    assign in_ready_w = advance && !hazard_w && !bus.flush;
    assign accept     = bus.in_valid && in_ready_w;

    always_ff @(posedge clk_in) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (bus.reg_en && !is_zero_reg(bus.reg_addr)) begin
            rf[bus.reg_addr] <= bus.reg_data;
        end
    end

    // Flush kills the slot but keeps the payload; only the opcode is parked on NOP.
    always_ff @(posedge clk_in) begin
        if (RST) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            pc_q    <= '0;
        end else if (bus.flush) begin
            valid_q                  <= 1'b0;
            ctrl_q[OPCODE_WIDTH-1:0] <= OP_NOP;
        end else if (accept) begin
            valid_q <= 1'b1;
            a_q     <= rd_a;
            b_q     <= rd_b;
            imm_q   <= imm_ext;
            ctrl_q  <= ctrl_dec;
            pc_q    <= bus.pc_in;
        end else if (advance) begin
            valid_q <= 1'b0;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] issued_q;
    logic [31:0] bubbles_q;

    always_ff @(posedge clk_in) begin
        if (RST) begin
            issued_q  <= '0;
            bubbles_q <= '0;
        end else begin
            if (accept)               issued_q  <= issued_q + 32'd1;
            if (hazard_w && advance)  bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign bus.perf_issued  = issued_q;
    assign bus.perf_bubbles = bubbles_q;
`else
    assign bus.perf_issued  = '0;
    assign bus.perf_bubbles = '0;
`endif

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.imm       = imm_q;
    assign bus.ctrl      = ctrl_q;
    assign bus.pc_out    = pc_q;
    assign bus.out_valid = valid_q;
    assign bus.in_ready  = in_ready_w;
    assign bus.hazard    = hazard_w;
endmodule

// File: tb/tb_decode_stage_v2.sv
// Directed bench for decode_stage_v2: reset, bypass, sign extension, load-use bubble,
// backpressure, zero register, flush and a back-to-back stream scored from a queue.
module tb_decode_stage_v2;
  localparam int DW  = 32;
  localparam int PW  = 16;
  localparam int OW  = 4;
  localparam int RAW = 5;
  localparam int IW  = 16;
  localparam int INSTR_W = OW + 2 * RAW + IW;

  localparam logic [3:0] LW  = 4'd0;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] SUB = 4'd3;

  logic clk_in = 1'b0;
  logic RST    = 1'b1;

  decode_stage_v2_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .OPCODE_WIDTH(OW),
                       .REG_ADDR_WIDTH(RAW), .IMM_WIDTH(IW)) bus ();

  decode_stage_v2 #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .OPCODE_WIDTH(OW),
                    .REG_ADDR_WIDTH(RAW), .IMM_WIDTH(IW), .R0_ZERO(1)) dut (
    .clk_in (clk_in),
    .RST    (RST),
    .bus    (bus)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [3:0] op, input logic [4:0] r1,
                                            input logic [4:0] r2, input logic [15:0] im);
    return {im, r2, r1, op};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [15:0] im, input logic [PW-1:0] pc);
    bus.instr    = mk(op, r1, r2, im);
    bus.pc_in    = pc;
    bus.in_valid = 1'b1;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [DW-1:0] data);
    bus.reg_addr = addr;
    bus.reg_data = data;
    bus.reg_en   = 1'b1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    bus.instr     = '0;
    bus.pc_in     = '0;
    bus.in_valid  = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_data  = '0;
    bus.reg_en    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #1;

    // 1: reset state and cleared register file
    do_reset();
    check("rst_valid", bus.out_valid, 0);
    check("rst_A", bus.A, 0);
    check("rst_B", bus.B, 0);
    check("rst_imm", bus.imm, 0);
    check("rst_ctrl", bus.ctrl, 0);
    check("rst_pc", bus.pc_out, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_perf_iss", bus.perf_issued, 0);
    check("rst_perf_bub", bus.perf_bubbles, 0);
    for (int i = 0; i < 32; i++) begin
      drive(ADD, 5'(i), 5'(31 - i), 16'h0, PW'(i));
      step();
      check($sformatf("rf_clear_A_r%0d", i), bus.A, 0);
      check($sformatf("rf_clear_B_r%0d", 31 - i), bus.B, 0);
    end
    bus.in_valid = 1'b0;
    step();
    check("idle_valid", bus.out_valid, 0);

    // 2: same-cycle writeback bypass into B
    wb(5'd3, 32'd9);
    drive(ADD, 5'd2, 5'd3, 16'h0, 16'd1024);
    step();
    bus.reg_en = 1'b0;
    bus.in_valid = 1'b0;
    check("byp_A", bus.A, 0);
    check("byp_B", bus.B, 9);
    check("byp_pc", bus.pc_out, 1024);
    check("byp_ctrl", bus.ctrl, 12'h822);
    check("byp_valid", bus.out_valid, 1);

    // 3: immediate sign extension on loads
    drive(LW, 5'd6, 5'd0, 16'h8000, 16'd2);
    step();
    check("imm_neg", bus.imm, 32'hFFFF8000);
    check("lw_ctrl6", bus.ctrl, 12'hC60);
    drive(LW, 5'd7, 5'd0, 16'h7FFF, 16'd3);
    #1;
    check("lw_nodep_ready", bus.in_ready, 1);
    check("lw_nodep_hazard", bus.hazard, 0);
    step();
    check("imm_pos", bus.imm, 32'h00007FFF);
    check("lw_ctrl7", bus.ctrl, 12'hC70);
    bus.in_valid = 1'b0;
    step();

    // 4: load-use hazard costs one bubble
    do_reset();
    drive(LW, 5'd5, 5'd0, 16'h0, 16'h10);
    step();
    check("lu_lw_valid", bus.out_valid, 1);
    check("lu_lw_ctrl", bus.ctrl, 12'hC50);
    drive(ADD, 5'd1, 5'd5, 16'h0, 16'h11);
    #1;
    check("lu_hazard", bus.hazard, 1);
    check("lu_in_ready", bus.in_ready, 0);
    step();
    check("lu_bubble_valid", bus.out_valid, 0);
    check("lu_hazard_clear", bus.hazard, 0);
    check("lu_ready_again", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("lu_add_valid", bus.out_valid, 1);
    check("lu_add_ctrl", bus.ctrl, 12'h812);
    check("lu_add_pc", bus.pc_out, 16'h11);
`ifdef DECODE_PERF_CNT_EN
    check("perf_issued", bus.perf_issued, 2);
    check("perf_bubbles", bus.perf_bubbles, 1);
`else
    check("perf_issued_off", bus.perf_issued, 0);
    check("perf_bubbles_off", bus.perf_bubbles, 0);
`endif

    // 5: backpressure holds the output while writeback still lands
    bus.out_ready = 1'b0;
    wb(5'd4, 32'd16);
    drive(ADD, 5'd4, 5'd0, 16'h0, 16'h20);
    #1;
    check("bp_in_ready", bus.in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      bus.reg_en = 1'b0;
      check($sformatf("bp_hold_valid%0d", c), bus.out_valid, 1);
      check($sformatf("bp_hold_ctrl%0d", c), bus.ctrl, 12'h812);
      check($sformatf("bp_hold_pc%0d", c), bus.pc_out, 16'h11);
      check($sformatf("bp_ready%0d", c), bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("bp_r4_A", bus.A, 16);
    check("bp_r4_pc", bus.pc_out, 16'h20);

    // 6: zero register, LW to r0 does not stall, flush
    wb(5'd0, 32'd5);
    drive(ADD, 5'd0, 5'd0, 16'h0, 16'h30);
    step();
    bus.reg_en = 1'b0;
    check("r0_A", bus.A, 0);
    drive(LW, 5'd0, 5'd0, 16'h0, 16'h31);
    step();
    drive(ADD, 5'd0, 5'd4, 16'h1234, 16'h40);
    #1;
    check("r0_lw_hazard", bus.hazard, 0);
    step();
    check("r0_after_lw_valid", bus.out_valid, 1);
    check("r0_B", bus.B, 16);
    check("r0_ctrl", bus.ctrl, 12'h802);
    bus.flush = 1'b1;
    drive(SUB, 5'd4, 5'd4, 16'h0, 16'h50);
    #1;
    check("fl_in_ready", bus.in_ready, 0);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_valid", bus.out_valid, 0);
    check("fl_ctrl", bus.ctrl, 12'h80F);
    check("fl_B_held", bus.B, 16);
    check("fl_pc_held", bus.pc_out, 16'h40);
    step();
    check("fl_not_taken", bus.out_valid, 0);

    // back-to-back stream scored against an expected queue
    for (int k = 0; k < 4; k++) begin
      wb(5'(10 + k), 32'h1000 + 32'(k) * 32'h111);
      step();
    end
    bus.reg_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(ADD, 5'(10 + k), 5'd0, 16'h0, PW'(16'h100 + k));
      exp_q.push_back(32'h1000 + 32'(k) * 32'h111);
      step();
      check($sformatf("str_valid%0d", k), bus.out_valid, 1);
      if (exp_q.size() > 0) check($sformatf("str_A%0d", k), bus.A, exp_q.pop_front());
    end
    bus.in_valid = 1'b0;
    step();
    check("str_drain", bus.out_valid, 0);
    check("str_q_empty", 64'(exp_q.size()), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage_v2.md
Name: decode_stage_v2

Overview:
Parametrised successor of the pipeline2 decode/register-read stage. It decodes one instruction per cycle, reads two operands from an internal register file and sign-extends the immediate. Results go into an output pipeline register behind a valid/ready handshake. Adds a configurable register file, write-to-read bypass, load-use hazard detection with bubble insertion, downstream backpressure and flush. It sits between the fetch stage and the execute stage; writeback drives the reg_* port.

Parameters:
DATA_WIDTH, 32, operand/register width
PC_WIDTH, 16, program counter width
OPCODE_WIDTH, 4, opcode field width
REG_ADDR_WIDTH, 5, register address width; register file has 2**REG_ADDR_WIDTH entries
IMM_WIDTH, 16, immediate field width; INSTR_WIDTH = OPCODE_WIDTH+2*REG_ADDR_WIDTH+IMM_WIDTH (localparam)
R0_ZERO, 1, 1 = register 0 reads as 0 and ignores writes
CTRL_WIDTH is a localparam: OPCODE_WIDTH+REG_ADDR_WIDTH+3

Ports:
clk_in  input  1  single clock, all state updates on the rising edge
RST  input  1  synchronous reset, active-high
pc_in  input  PC_WIDTH  PC of the incoming instruction
instr  input  INSTR_WIDTH  bit fields from LSB upward: opcode, rs1, rs2, imm
in_valid  input  1  instr/pc_in valid
in_ready  output  1  stage accepts instr this cycle (combinational)
reg_addr  input  REG_ADDR_WIDTH  writeback address
reg_data  input  DATA_WIDTH  writeback data
reg_en  input  1  writeback enable
flush  input  1  discard the output-register contents
A  output  DATA_WIDTH  signed operand read from rs1
B  output  DATA_WIDTH  signed operand read from rs2
imm  output  DATA_WIDTH  sign-extended immediate
ctrl  output  CTRL_WIDTH  {wb_en, mem_rd, mem_wr, rd_addr, opcode}
pc_out  output  PC_WIDTH  registered pc_in
out_valid  output  1  output register holds a valid instruction
out_ready  input  1  execute stage accepts this cycle
hazard  output  1  load-use stall indication (combinational)
perf_issued  output  32  perf counter: instructions issued (see Optional Feature)
perf_bubbles  output  32  perf counter: bubbles inserted (see Optional Feature)

Behaviour:
- Opcode encoding: LW=0, SW=1, ADD=2, SUB=3, MUL=4, DIV=5, AND=6, OR=7, NOT=8, CMP=9, JR=10, JPC=11, BRFL=12, CALL=13, RET=14, NOP=15.
- Field roles: rd_addr = rs1.
  - wb_en=1 for LW, ADD, SUB, MUL, DIV, AND, OR, NOT and CALL.
  - mem_rd=1 only for LW.
  - mem_wr=1 only for SW.
- Reset: when RST=1 at a rising edge:
  - all register-file entries are cleared to 0;
  - out_valid, A, B, imm, ctrl and pc_out go to 0;
  - perf counters go to 0.
  - Reset has priority over every other input.
- Writeback: if reg_en=1 at an edge, regfile[reg_addr] <= reg_data. The write ignores stall, hazard and flush. It is dropped when reg_addr=0 and R0_ZERO=1.
- Bypass: when reg_en=1, reg_addr==rs1 and the address is not a zero register, the captured A is reg_data; B uses the same rule with rs2. Same-cycle write and read therefore return the new value.
- advance = !out_valid | out_ready.
- hazard = in_valid & out_valid & ctrl.mem_rd & (ctrl.rd_addr==rs1 | ctrl.rd_addr==rs2). hazard is forced to 0 when ctrl.rd_addr=0 and R0_ZERO=1.
- in_ready = advance & !hazard.
- Edge priority after reset:
  - flush=1: out_valid <= 0 and ctrl.opcode <= NOP; other fields are held. An input presented in the same cycle is not accepted, and in_ready is forced to 0 while flush=1.
  - else if advance & in_valid & !hazard: capture A, B, imm, ctrl and pc_out; out_valid <= 1.
  - else if advance: out_valid <= 0. This covers both a bubble on hazard and an empty input.
  - else (stalled): all output registers are held.
- Latency: exactly 1 cycle from acceptance to out_valid. Throughput is 1 per cycle with no hazards.
- A load-use hazard costs exactly 1 bubble cycle. The LW leaves the stage, and the dependent instruction is accepted on the following edge.
- imm is sign-extended from IMM_WIDTH to DATA_WIDTH. A and B are signed.
- pc_out and the register file do not wrap or saturate; pc_in is passed through unmodified.

Optional Feature:
DECODE_PERF_CNT_EN
- Defined: perf_issued increments on every accepted instruction, and perf_bubbles increments on every edge where hazard=1 and advance=1. Both are 32-bit, wrap from 0xFFFFFFFF to 0 and are cleared by RST.
- Not defined: the counter logic is absent and both ports are tied to 0.

Test Plan:
1. RST=1 for 1 cycle then RST=0 -> out_valid=0, A=B=imm=0, ctrl=0, pc_out=0; a subsequent read of r0..r31 returns 0.
2. Same cycle: reg_en=1, reg_addr=3, reg_data=9, plus ADD rs1=2, rs2=3, imm=0, pc_in=1024, in_valid=1 -> next edge A=0, B=9, pc_out=1024, ctrl opcode=2, wb_en=1, out_valid=1.
3. LW imm=16'h8000 -> imm=32'hFFFF8000; then LW imm=16'h7FFF -> imm=32'h00007FFF; ctrl mem_rd=1.
4. Accept LW rs1=5, then present ADD rs1=1, rs2=5 with out_ready=1 -> hazard=1, in_ready=0, next edge out_valid=0 (bubble); the following edge ADD is accepted and out_valid=1. With the macro defined, perf_bubbles=1 and perf_issued=2.
5. out_valid=1, out_ready=0 for 3 cycles while reg_en writes r4=16 -> outputs held and in_ready=0. After out_ready=1, reading r4 returns 16.
6. reg_en write r0=5 (R0_ZERO=1), then read rs1=0 -> A=0. flush=1 while out_valid=1 -> next edge out_valid=0, ctrl opcode=15 (NOP).
